id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter REG_AW, default 5, GPR address width.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 inst_valid_i  input  1  instruction from IF/ID is present.
REQ-006 inst_i  input  32  instruction word.
REQ-007 inst_ready_o  output  1  stage consumes inst_i this cycle.
REQ-008 reg1_read_o / reg2_read_o  output  1 each  GPR port read enables (combinational).
REQ-009 reg1_addr_o / reg2_addr_o  output  REG_AW each  GPR port addresses, inst_i[25:21] / inst_i[20:16].
REQ-010 reg1_data_i / reg2_data_i  input  DATA_W each  GPR read data.
REQ-011 ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  input  1/REG_AW/DATA_W/1  EX-stage write-back bypass.
REQ-012 mem_wreg_i, mem_wd_i, mem_wdata_i  input  1/REG_AW/DATA_W  MEM-stage write-back bypass.
REQ-013 flush_i  input  1  discard registered and incoming instruction.
REQ-014 out_valid_o  output  1  ID/EX register holds a valid instruction.
REQ-015 out_ready_i  input  1  EX accepts the ID/EX register.
REQ-016 aluop_o 8, alusel_o 3, reg1_o DATA_W, reg2_o DATA_W, wd_o REG_AW, wreg_o 1, inst_err_o 1  outputs  registered decode result.

Function
REQ-017 Decoded set: ORI 001101, ANDI 001100, XORI 001110, LUI 001111; SPECIAL 000000 with funct AND 100100, OR 100101, XOR 100110, NOR 100111; all LOGIC alusel.
REQ-018 I-type: reg1 read from rs, reg2_o = immediate, wd = rt; ORI/ANDI/XORI zero-extend imm to DATA_W; LUI operand = {imm,16'h0} sign-extended to DATA_W, reg1 unread, reg1_o = 0, aluop OR.
REQ-019 R-type: both ports read, wd = rd; SPECIAL with shamt != 0 or unlisted funct is invalid.
REQ-020 Invalid opcode: decode as NOP (aluop/alusel NOP, wreg 0, wd 0, operands 0), inst_err_o = 1 for that slot; no stall.
REQ-021 Operand source per read port, priority: address 0 -> zero; EX match (ex_wreg_i, ex_wd_i == addr) -> ex_wdata_i; MEM match -> mem_wdata_i; else GPR data.
REQ-022 Load-use hazard: inst_valid_i and ex_is_load_i and ex_wreg_i and ex_wd_i != 0 and matches an enabled read port.
REQ-023 Register enable: en = !out_valid_o or out_ready_i.
REQ-024 inst_ready_o = en and not hazard; inst_ready_o = 1 whenever flush_i = 1.
REQ-025 On en, no hazard, no flush: ID/EX register loads decode, out_valid_o <= inst_valid_i; latency 1 cycle.
REQ-026 On en with hazard: register loads bubble, out_valid_o <= 0, instruction held upstream.
REQ-027 Stall: out_valid_o = 1 and out_ready_i = 0 -> all registered outputs hold unchanged.
REQ-028 flush_i = 1: next cycle out_valid_o = 0 irrespective of en/hazard; any inst_i offered is consumed and dropped.
REQ-029 out_valid_o = 0 implies wreg_o = 0.

Reset
REQ-030 rst low asynchronously forces out_valid_o 0, aluop/alusel NOP, reg1_o/reg2_o 0, wd_o 0, wreg_o 0, inst_err_o 0.
REQ-031 During reset inst_ready_o, reg1_read_o, reg2_read_o = 0; reg addresses = 0.
REQ-032 Reset mid-stall or mid-flush discards the held instruction; first valid output after release needs a new accept.

Structure
REQ-033 Opcodes, funct codes, aluop/alusel encodings, ZeroWord, NOP register address live in shared defines.v.
REQ-034 Combinational decoder as sub-module id_decode (inst in; aluop, alusel, read enables, wd, wreg, imm, err out); id_stage owns bypass, hazard, handshake, ID/EX register.

Verification
REQ-035 ORI $1,$0,0x1100 valid, out_ready_i 1 -> next cycle out_valid 1, aluop OR, reg1_o 0, reg2_o 0x00001100, wd 1, wreg 1.
REQ-036 OR $3,$1,$2, EX writes $1=0xAAAA0000 and MEM writes $1=0x5555 and $2=0x0F -> reg1_o 0xAAAA0000, reg2_o 0x0000000F.
REQ-037 ex_is_load_i writing $4, then ANDI $5,$4,0xFF -> inst_ready_o 0 one cycle, bubble out; after load clears, ANDI issued once.
REQ-038 out_ready_i 0 for 3 cycles with LUI $6,0x8000, DATA_W 64 -> reg2_o holds 0xFFFFFFFF80000000, inst_ready_o 0, outputs stable.
REQ-039 Opcode 111111 -> inst_err_o 1, wreg_o 0; flush_i same cycle as next ORI -> out_valid_o 0, ORI never emitted.
REQ-040 rst low while stalled with valid output -> out_valid_o 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared opcode, funct and ALU encodings for the decode stage
package id_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [7:0] {
    ALUOP_NOP = 8'b0000_0000,
    ALUOP_AND = 8'b0010_0100,
    ALUOP_OR  = 8'b0010_0101,
    ALUOP_XOR = 8'b0010_0110,
    ALUOP_NOR = 8'b0010_0111
  } aluop_e;

  typedef enum logic [2:0] {
    ALUSEL_NOP   = 3'b000,
    ALUSEL_LOGIC = 3'b001
  } alusel_e;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  // ALUOP_NOP doubles as "funct not in the decoded set".
  function automatic aluop_e funct_aluop(input logic [5:0] funct);
    case (funct)
      FN_AND:  return ALUOP_AND;
      FN_OR:   return ALUOP_OR;
      FN_XOR:  return ALUOP_XOR;
      FN_NOR:  return ALUOP_NOR;
      default: return ALUOP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_decode.sv
// rtl/id_stage_decode.sv - combinational instruction decoder for the logic subset
module id_decode
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst_i,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              err_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  aluop_e      r_aluop;

  assign op      = inst_i[31:26];
  assign shamt   = inst_i[10:6];
  assign funct   = inst_i[5:0];
  assign imm16   = inst_i[15:0];
  assign r_aluop = funct_aluop(funct);

  always_comb begin
    aluop_o     = ALUOP_NOP;
    alusel_o    = ALUSEL_NOP;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    wd_o        = REG_AW'(NOP_REG_ADDR);
    wreg_o      = 1'b0;
    imm_o       = '0;
    err_o       = 1'b0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        aluop_o     = (op == OP_ORI)  ? ALUOP_OR :
                      (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
        alusel_o    = ALUSEL_LOGIC;
        reg1_read_o = 1'b1;
        wd_o        = REG_AW'(inst_i[20:16]);
        wreg_o      = 1'b1;
        imm_o       = DATA_W'(imm16);
      end
      OP_LUI: begin
        // LUI is executed as 0 | {imm,16'h0}, so rs is never read.
        aluop_o  = ALUOP_OR;
        alusel_o = ALUSEL_LOGIC;
        wd_o     = REG_AW'(inst_i[20:16]);
        wreg_o   = 1'b1;
        imm_o    = DATA_W'(signed'({imm16, 16'h0000}));
      end
      OP_SPECIAL: begin
        if (shamt == 5'd0 && r_aluop != ALUOP_NOP) begin
          aluop_o     = r_aluop;
          alusel_o    = ALUSEL_LOGIC;
          reg1_read_o = 1'b1;
          reg2_read_o = 1'b1;
          wd_o        = REG_AW'(inst_i[15:11]);
          wreg_o      = 1'b1;
        end else begin
          err_o = 1'b1;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage with operand bypass, load-use stall and ID/EX register
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [31:0]       inst_i,
  output logic              inst_ready_o,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              inst_err_o
);

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_read1, dec_read2, dec_wreg, dec_err;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;

  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .inst_i      (inst_i),
    .aluop_o     (dec_aluop),
    .alusel_o    (dec_alusel),
    .reg1_read_o (dec_read1),
    .reg2_read_o (dec_read2),
    .wd_o        (dec_wd),
    .wreg_o      (dec_wreg),
    .imm_o       (dec_imm),
    .err_o       (dec_err)
  );

  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] src1, src2;
  logic              hazard, en;

  logic              out_valid_q, out_valid_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d, err_q, err_d;

  function automatic logic [DATA_W-1:0] bypass(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] gpr,
    input logic              exw,
    input logic [REG_AW-1:0] exd,
    input logic [DATA_W-1:0] exv,
    input logic              memw,
    input logic [REG_AW-1:0] memd,
    input logic [DATA_W-1:0] memv
  );
    if (addr == '0)                return '0;
    else if (exw && exd == addr)   return exv;
    else if (memw && memd == addr) return memv;
    else                           return gpr;
  endfunction

  assign rs = REG_AW'(inst_i[25:21]);
  assign rt = REG_AW'(inst_i[20:16]);

  assign src1 = bypass(rs, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign src2 = bypass(rt, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign hazard = inst_valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                  ((dec_read1 && ex_wd_i == rs) || (dec_read2 && ex_wd_i == rt));
  assign en     = !out_valid_q || out_ready_i;

  assign inst_ready_o = rst && (flush_i || (en && !hazard));
  assign reg1_read_o  = rst && dec_read1;
  assign reg2_read_o  = rst && dec_read2;
  assign reg1_addr_o  = rst ? rs : '0;
  assign reg2_addr_o  = rst ? rt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    err_d       = err_q;
    // Flush, load-use bubble and empty slots all load the same NOP image.
    if (flush_i || (en && (hazard || !inst_valid_i))) begin
      out_valid_d = 1'b0;
      aluop_d     = ALUOP_NOP;
      alusel_d    = ALUSEL_NOP;
      reg1_d      = '0;
      reg2_d      = '0;
      wd_d        = '0;
      wreg_d      = 1'b0;
      err_d       = 1'b0;
    end else if (en) begin
      out_valid_d = 1'b1;
      aluop_d     = dec_aluop;
      alusel_d    = dec_alusel;
      reg1_d      = dec_read1 ? src1 : '0;
      reg2_d      = dec_read2 ? src2 : dec_imm;
      wd_d        = dec_wd;
      wreg_d      = dec_wreg;
      err_d       = dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      aluop_q     <= ALUOP_NOP;
      alusel_q    <= ALUSEL_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign inst_err_o  = err_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a rule-level reference model
module tb_id_stage;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_valid_i, inst_ready_o;
  logic [31:0]   inst_i;
  logic          reg1_read_o, reg2_read_o;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o;
  logic [DW-1:0] reg1_data_i, reg2_data_i;
  logic          ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [AW-1:0] ex_wd_i, mem_wd_i;
  logic [DW-1:0] ex_wdata_i, mem_wdata_i;
  logic          flush_i, out_valid_o, out_ready_i;
  logic [7:0]    aluop_o;
  logic [2:0]    alusel_o;
  logic [DW-1:0] reg1_o, reg2_o;
  logic [AW-1:0] wd_o;
  logic          wreg_o, inst_err_o;

  id_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .inst_ready_o(inst_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .inst_err_o(inst_err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          v;
    logic [7:0]    op;
    logic [2:0]    sel;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [AW-1:0] wd;
    logic          wreg;
    logic          err;
  } regs_t;

  typedef struct packed {
    logic          ok;
    logic [7:0]    op;
    logic          use1;
    logic          use2;
    logic [4:0]    dst;
    logic [DW-1:0] imm;
  } dec_t;

  regs_t       m_cur, m_nxt;
  logic [12:0] m_comb;

  function automatic regs_t dut_regs();
    return {out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_err_o};
  endfunction

  function automatic logic [12:0] dut_comb();
    return {inst_ready_o, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d = '0;
    d.ok = 1'b1; d.use1 = 1'b1; d.dst = i[20:16]; d.imm = {48'h0, i[15:0]};
    case (i[31:26])
      6'b001101: d.op = 8'h25;
      6'b001100: d.op = 8'h24;
      6'b001110: d.op = 8'h26;
      6'b001111: begin d.op = 8'h25; d.use1 = 1'b0; d.imm = {{32{i[15]}}, i[15:0], 16'h0}; end
      6'b000000: begin
        d.use2 = 1'b1; d.dst = i[15:11]; d.imm = '0;
        case (i[5:0])
          6'b100100: d.op = 8'h24;
          6'b100101: d.op = 8'h25;
          6'b100110: d.op = 8'h26;
          6'b100111: d.op = 8'h27;
          default:   d.ok = 1'b0;
        endcase
        if (i[10:6] != 5'd0) d.ok = 1'b0;
      end
      default: d.ok = 1'b0;
    endcase
    if (!d.ok) d = '0;
    return d;
  endfunction

  function automatic logic [DW-1:0] src(input logic [4:0] a, input logic [DW-1:0] gpr);
    if (a == 5'd0) return '0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return gpr;
  endfunction

  task automatic settle();
    dec_t d;
    logic haz, open;
    #1;
    if (!rst) begin
      m_cur = '0; m_nxt = '0; m_comb = '0;
      return;
    end
    d    = ref_decode(inst_i);
    haz  = inst_valid_i && ex_is_load_i && ex_wreg_i && ex_wd_i != 5'd0 &&
           ((d.use1 && ex_wd_i == inst_i[25:21]) || (d.use2 && ex_wd_i == inst_i[20:16]));
    open = !m_cur.v || out_ready_i;
    m_comb = {flush_i || (open && !haz), d.use1, d.use2, inst_i[25:21], inst_i[20:16]};
    if (flush_i || (open && (haz || !inst_valid_i))) m_nxt = '0;
    else if (!open) m_nxt = m_cur;
    else begin
      m_nxt = '0;
      m_nxt.v = 1'b1;
      if (!d.ok) m_nxt.err = 1'b1;
      else begin
        m_nxt.op   = d.op;
        m_nxt.sel  = 3'b001;
        m_nxt.r1   = d.use1 ? src(inst_i[25:21], reg1_data_i) : '0;
        m_nxt.r2   = d.use2 ? src(inst_i[20:16], reg2_data_i) : d.imm;
        m_nxt.wd   = d.dst;
        m_nxt.wreg = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_cur = m_nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    inst_valid_i = 0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
    ex_wreg_i = 0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = '0; mem_wdata_i = '0; flush_i = 0; out_ready_i = 1;
  endtask

  task automatic test_reset();
    idle();
    inst_valid_i = 1; inst_i = itype(6'b001101, 5'd2, 5'd3, 16'h1234);
    settle();
    vectors++;
    if (dut_comb() !== 13'd0) begin
      miscompares++; $display("FAIL reset_comb: got %h want 0", dut_comb());
    end
    tick();
    vectors++;
    if (dut_regs() !== '0) begin
      miscompares++; $display("FAIL reset_regs: got %h want 0", dut_regs());
    end
    rst = 1;
  endtask

  task automatic test_ori();
    idle();
    inst_valid_i = 1; inst_i = itype(6'b001101, 5'd0, 5'd1, 16'h1100);
    settle();
    vectors++;
    if (dut_comb() !== m_comb) begin
      miscompares++; $display("FAIL ori_comb: got %h want %h", dut_comb(), m_comb);
    end
    tick();
    vectors++;
    if (out_valid_o !== 1'b1 || aluop_o !== 8'h25 || alusel_o !== 3'b001 || reg1_o !== '0 ||
        reg2_o !== 64'h1100 || wd_o !== 5'd1 || wreg_o !== 1'b1 || dut_regs() !== m_cur) begin
      miscompares++; $display("FAIL ori_issue: got %h want %h", dut_regs(), m_cur);
    end
    inst_valid_i = 0;
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b0 || wreg_o !== 1'b0) begin
      miscompares++; $display("FAIL ori_drain: valid %b wreg %b want 0 0", out_valid_o, wreg_o);
    end
  endtask

  task automatic test_bypass();
    idle();
    inst_valid_i = 1; inst_i = rtype(6'b100101, 5'd1, 5'd2, 5'd3);
    reg1_data_i = 64'h1111; reg2_data_i = 64'h2222;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 64'hAAAA0000;
    mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 64'h0F;
    settle(); tick();
    vectors++;
    if (reg1_o !== 64'hAAAA0000 || reg2_o !== 64'h0F || wd_o !== 5'd3 || dut_regs() !== m_cur) begin
      miscompares++; $display("FAIL bypass_ex_mem: r1 %h r2 %h want aaaa0000 f", reg1_o, reg2_o);
    end
    mem_wd_i = 5'd1; mem_wdata_i = 64'h5555;
    settle(); tick();
    vectors++;
    if (reg1_o !== 64'hAAAA0000 || reg2_o !== 64'h2222) begin
      miscompares++; $display("FAIL bypass_priority: r1 %h r2 %h want aaaa0000 2222", reg1_o, reg2_o);
    end
    inst_i = rtype(6'b100111, 5'd0, 5'd1, 5'd4); ex_wd_i = 5'd0; mem_wd_i = 5'd1;
    settle(); tick();
    vectors++;
    if (reg1_o !== '0 || reg2_o !== 64'h5555 || aluop_o !== 8'h27) begin
      miscompares++; $display("FAIL bypass_zero: r1 %h r2 %h op %h want 0 5555 27", reg1_o, reg2_o, aluop_o);
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4; ex_wdata_i = 64'hDEAD;
    inst_valid_i = 1; inst_i = itype(6'b001100, 5'd4, 5'd5, 16'h00FF);
    settle();
    vectors++;
    if (inst_ready_o !== 1'b0 || dut_comb() !== m_comb) begin
      miscompares++; $display("FAIL loaduse_stall: ready %b want 0", inst_ready_o);
    end
    tick();
    vectors++;
    if (out_valid_o !== 1'b0 || wreg_o !== 1'b0) begin
      miscompares++; $display("FAIL loaduse_bubble: valid %b wreg %b want 0 0", out_valid_o, wreg_o);
    end
    ex_is_load_i = 0; ex_wreg_i = 0; mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 64'hBEEF;
    settle();
    vectors++;
    if (inst_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL loaduse_release: ready %b want 1", inst_ready_o);
    end
    tick();
    vectors++;
    if (out_valid_o !== 1'b1 || aluop_o !== 8'h24 || reg1_o !== 64'hBEEF || reg2_o !== 64'hFF ||
        wd_o !== 5'd5 || dut_regs() !== m_cur) begin
      miscompares++; $display("FAIL loaduse_issue: got %h want %h", dut_regs(), m_cur);
    end
    inst_valid_i = 0;
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL loaduse_once: valid %b want 0", out_valid_o);
    end
  endtask

  task automatic test_stall_lui();
    idle();
    inst_valid_i = 1; inst_i = itype(6'b001111, 5'd9, 5'd6, 16'h8000);
    settle(); tick();
    out_ready_i = 0; inst_i = itype(6'b001101, 5'd0, 5'd7, 16'h0042);
    for (int k = 0; k < 3; k++) begin
      settle();
      vectors++;
      if (inst_ready_o !== 1'b0) begin
        miscompares++; $display("FAIL stall_ready[%0d]: ready %b want 0", k, inst_ready_o);
      end
      tick();
      vectors++;
      if (out_valid_o !== 1'b1 || reg2_o !== 64'hFFFFFFFF80000000 || reg1_o !== '0 ||
          wd_o !== 5'd6 || dut_regs() !== m_cur) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", k, dut_regs(), m_cur);
      end
    end
    out_ready_i = 1;
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b1 || wd_o !== 5'd7 || reg2_o !== 64'h42) begin
      miscompares++; $display("FAIL stall_resume: wd %0d r2 %h want 7 42", wd_o, reg2_o);
    end
  endtask

  task automatic test_invalid_flush();
    idle();
    inst_valid_i = 1; inst_i = {6'b111111, 26'h1234567};
    settle(); tick();
    vectors++;
    if (inst_err_o !== 1'b1 || wreg_o !== 1'b0 || out_valid_o !== 1'b1 || aluop_o !== 8'h00) begin
      miscompares++; $display("FAIL invalid_op: err %b wreg %b want 1 0", inst_err_o, wreg_o);
    end
    inst_i = itype(6'b001101, 5'd0, 5'd1, 16'h1100); flush_i = 1;
    settle();
    vectors++;
    if (inst_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_ready: ready %b want 1", inst_ready_o);
    end
    tick();
    inst_valid_i = 0; flush_i = 0;
    vectors++;
    if (out_valid_o !== 1'b0 || inst_err_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop: valid %b want 0", out_valid_o);
    end
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_never: valid %b want 0", out_valid_o);
    end
    inst_valid_i = 1; settle(); tick();
    out_ready_i = 0; flush_i = 1; settle(); tick();
    flush_i = 0; inst_valid_i = 0;
    vectors++;
    if (out_valid_o !== 1'b0 || dut_regs() !== m_cur) begin
      miscompares++; $display("FAIL flush_stalled: valid %b want 0", out_valid_o);
    end
  endtask

  task automatic test_reset_midstall();
    idle();
    inst_valid_i = 1; inst_i = itype(6'b001110, 5'd3, 5'd8, 16'h00F0); reg1_data_i = 64'h77;
    settle(); tick();
    out_ready_i = 0;
    #2;
    rst = 0;
    #1;
    vectors++;
    if (dut_regs() !== '0 || dut_comb() !== 13'd0) begin
      miscompares++; $display("FAIL reset_async: regs %h comb %h want 0 0", dut_regs(), dut_comb());
    end
    settle(); tick();
    rst = 1; inst_valid_i = 0; out_ready_i = 1;
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_discard: valid %b want 0", out_valid_o);
    end
    inst_valid_i = 1;
    settle(); tick();
    vectors++;
    if (out_valid_o !== 1'b1 || reg1_o !== 64'h77 || reg2_o !== 64'hF0 || dut_regs() !== m_cur) begin
      miscompares++; $display("FAIL reset_reaccept: got %h want %h", dut_regs(), m_cur);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs  = 5'($urandom_range(0, 7));
    logic [4:0]  rt  = 5'($urandom_range(0, 7));
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    int          k   = $urandom_range(0, 9);
    case (k)
      0: return itype(6'b001101, rs, rt, imm);
      1: return itype(6'b001100, rs, rt, imm);
      2: return itype(6'b001110, rs, rt, imm);
      3: return itype(6'b001111, 5'($urandom), rt, imm);
      4, 5, 6, 7: return rtype(6'b100100 + 6'(k - 4), rs, rt, rd);
      8: return $urandom;
      default: return {6'b000000, rs, rt, rd, 5'($urandom), 6'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 49) != 0);
      inst_valid_i = ($urandom_range(0, 9) < 8);
      inst_i       = rand_inst();
      reg1_data_i  = {$urandom, $urandom};
      reg2_data_i  = {$urandom, $urandom};
      ex_wreg_i    = $urandom_range(0, 1);
      ex_wd_i      = 5'($urandom_range(0, 7));
      ex_wdata_i   = {$urandom, $urandom};
      ex_is_load_i = ($urandom_range(0, 3) == 0);
      mem_wreg_i   = $urandom_range(0, 1);
      mem_wd_i     = 5'($urandom_range(0, 7));
      mem_wdata_i  = {$urandom, $urandom};
      flush_i      = ($urandom_range(0, 9) == 0);
      out_ready_i  = ($urandom_range(0, 9) < 7);
      settle();
      vectors++;
      if (dut_comb() !== m_comb) begin
        miscompares++; $display("FAIL rand_comb[%0d]: got %h want %h", n, dut_comb(), m_comb);
      end
      tick();
      vectors++;
      if (dut_regs() !== m_cur) begin
        miscompares++; $display("FAIL rand_regs[%0d]: got %h want %h", n, dut_regs(), m_cur);
      end
    end
    rst = 1;
  endtask

  initial begin
    rst = 0;
    m_cur = '0; m_nxt = '0; m_comb = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_ori();
    test_bypass();
    test_load_use();
    test_stall_lui();
    test_invalid_flush();
    test_reset_midstall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
